// File: rtl/rosc_meas_sequencer.sv
// Stress/measure sequencer for the three-ring ROSC block; build with ROSC_SAT_CNT_EN for a saturating counter (default wraps).
// Latency: all outputs registered, one CLK after the deciding input; each result is held in REPORT until accepted.
// Backpressure: cnt_valid/cnt_ready handshake; the sequence stalls in REPORT while cnt_ready is low.
module rosc_meas_sequencer #(
    parameter int CNT_W      = 16,
    parameter int STRESS_W   = 24,
    parameter int SETTLE_CYC = 64,
    parameter int GATE_CYC   = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                abort,
    input  logic                cont,
    input  logic                ac_mode,
    input  logic [2:0]          ring_mask,
    input  logic [STRESS_W-1:0] stress_len,
    input  logic                rosc_out,
    output logic                sel_inv,
    output logic                sel_nand,
    output logic                sel_nor,
    output logic                start,
    output logic                ac_dc,
    output logic                en_power_rosc,
    output logic                en_rosc,
    output logic                meas_stress,
    output logic                cnt_valid,
    input  logic                cnt_ready,
    output logic [CNT_W-1:0]    cnt_data,
    output logic [1:0]          cnt_ring,
    output logic                cnt_ovf,
    output logic                busy,
    output logic                done
);
    localparam int TMR_W0 = (STRESS_W > $clog2(GATE_CYC)) ? STRESS_W : $clog2(GATE_CYC);
    localparam int TMR_W  = (TMR_W0 > $clog2(SETTLE_CYC)) ? TMR_W0 : $clog2(SETTLE_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_STRESS, S_SETTLE, S_GATE, S_REPORT} state_t;

    state_t                state, state_nxt;
    logic [1:0]            ring, ring_nxt;
    logic [TMR_W-1:0]      tmr, tmr_nxt, in_len_ld, cfg_len_ld;
    logic                  cfg_cont, cfg_ac;
    logic [2:0]            cfg_mask, pick;
    logic [STRESS_W-1:0]   cfg_len;
    logic                  done_nxt, meas_nxt, ac_eff;
    logic                  s1, s2, s3, rise;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  ovf, ovf_nxt;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [2:0] find_ring(input logic [2:0] mask, input logic [2:0] from);
        find_ring = 3'b000;
        for (int i = 2; i >= 0; i--)
            if (mask[i] && i >= int'(from)) find_ring = {1'b1, 2'(i)};
    endfunction

    assign in_len_ld  = (stress_len != '0) ? TMR_W'(stress_len) - TMR_ONE : '0;
    assign cfg_len_ld = (cfg_len != '0) ? TMR_W'(cfg_len) - TMR_ONE : '0;

    always_comb begin
        state_nxt = state;
        ring_nxt  = ring;
        done_nxt  = 1'b0;
        pick      = 3'b000;
        tmr_nxt   = (tmr != '0) ? tmr - TMR_ONE : tmr;
        case (state)
            S_IDLE: if (run) begin
                pick = find_ring(ring_mask, 3'd0);
                if (stress_len != '0 || !pick[2]) begin
                    state_nxt = S_STRESS;
                    tmr_nxt   = in_len_ld;
                end else begin
                    state_nxt = S_SETTLE;
                    ring_nxt  = pick[1:0];
                    tmr_nxt   = SETTLE_LD;
                end
            end
            S_STRESS: if (tmr == '0) begin
                pick = find_ring(cfg_mask, 3'd0);
                if (pick[2]) begin
                    state_nxt = S_SETTLE;
                    ring_nxt  = pick[1:0];
                    tmr_nxt   = SETTLE_LD;
                end else if (cfg_cont) begin
                    tmr_nxt = cfg_len_ld;
                end else begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            S_SETTLE: if (tmr == '0) begin
                state_nxt = S_GATE;
                tmr_nxt   = GATE_LD;
            end
            S_GATE: if (tmr == '0) state_nxt = S_REPORT;
            S_REPORT: if (cnt_valid && cnt_ready) begin
                pick = find_ring(cfg_mask, {1'b0, ring} + 3'd1);
                if (!pick[2] && cfg_cont) pick = find_ring(cfg_mask, 3'd0);
                if (cfg_cont && pick[2] == 1'b1 && find_ring(cfg_mask, {1'b0, ring} + 3'd1) == 3'b000
                        && cfg_len != '0) begin
                    state_nxt = S_STRESS;
                    tmr_nxt   = cfg_len_ld;
                end else if (pick[2]) begin
                    state_nxt = S_SETTLE;
                    ring_nxt  = pick[1:0];
                    tmr_nxt   = SETTLE_LD;
                end else begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort overrides everything, including a same-cycle RUN.
        if (abort) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b0;
        end
    end

    assign rise = s2 & ~s3;

    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (rise) begin
`ifdef ROSC_SAT_CNT_EN
            if (&cnt) ovf_nxt = 1'b1;
            else      cnt_nxt = cnt + CNT_ONE;
`else
            cnt_nxt = cnt + CNT_ONE;
            if (&cnt) ovf_nxt = 1'b1;
`endif
        end
    end

    assign meas_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_GATE) || (state_nxt == S_REPORT);
    assign ac_eff   = (state == S_IDLE) ? ac_mode : cfg_ac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;  ring <= 2'd0;  tmr <= '0;
            cfg_cont <= 1'b0; cfg_ac <= 1'b0; cfg_mask <= 3'b000; cfg_len <= '0;
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
            cnt <= '0; ovf <= 1'b0;
            sel_inv <= 1'b0; sel_nand <= 1'b0; sel_nor <= 1'b0;
            start <= 1'b0; ac_dc <= 1'b0; en_power_rosc <= 1'b0; en_rosc <= 1'b0;
            meas_stress <= 1'b0; cnt_valid <= 1'b0; cnt_data <= '0; cnt_ring <= 2'd0;
            cnt_ovf <= 1'b0; busy <= 1'b0; done <= 1'b0;
        end else begin
            state <= state_nxt;
            ring  <= ring_nxt;
            tmr   <= tmr_nxt;
            if (state == S_IDLE && run && !abort) begin
                cfg_cont <= cont;  cfg_ac  <= ac_mode;
                cfg_mask <= ring_mask; cfg_len <= stress_len;
            end
            s1 <= rosc_out; s2 <= s1; s3 <= s2;
            if (state != S_GATE && state_nxt == S_GATE) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (state == S_GATE) begin
                cnt <= cnt_nxt;
                ovf <= ovf_nxt;
            end
            sel_inv       <= meas_nxt && ring_nxt == 2'd0;
            sel_nand      <= meas_nxt && ring_nxt == 2'd1;
            sel_nor       <= meas_nxt && ring_nxt == 2'd2;
            start         <= state_nxt == S_STRESS;
            ac_dc         <= state_nxt == S_STRESS && ac_eff;
            en_power_rosc <= state_nxt != S_IDLE;
            en_rosc       <= meas_nxt;
            meas_stress   <= meas_nxt;
            cnt_valid     <= state_nxt == S_REPORT;
            busy          <= state_nxt != S_IDLE;
            done          <= done_nxt;
            if (state_nxt != S_REPORT) cnt_ovf <= 1'b0;
            else if (state == S_GATE)  cnt_ovf <= ovf_nxt;
            if (state == S_GATE && state_nxt == S_REPORT) begin
                cnt_data <= cnt_nxt;
                cnt_ring <= ring;
            end
        end
    end
endmodule

// File: tb/tb_rosc_meas_sequencer.sv
// Directed bench for rosc_meas_sequencer (8-bit counter, 64-cycle settle, 1024-cycle gate).
module tb_rosc_meas_sequencer;
    logic        clk = 1'b0, clk_en = 1'b1, rst_n = 1'b0;
    logic        run = 1'b0, abort = 1'b0, cont = 1'b0, ac_mode = 1'b0, cnt_ready = 1'b0;
    logic [2:0]  ring_mask = 3'b000;
    logic [23:0] stress_len = 24'd0;
    logic        rosc_out = 1'b0;
    int          rosc_div = 8;
    logic        sel_inv, sel_nand, sel_nor, start, ac_dc, en_power_rosc, en_rosc, meas_stress;
    logic        cnt_valid, cnt_ovf, busy, done;
    logic [7:0]  cnt_data;
    logic [1:0]  cnt_ring;
    logic [11:0] ctl;
    int          n_tests = 0, n_fail = 0;

    rosc_meas_sequencer #(.CNT_W(8), .STRESS_W(24), .SETTLE_CYC(64), .GATE_CYC(1024)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .abort(abort), .cont(cont), .ac_mode(ac_mode),
        .ring_mask(ring_mask), .stress_len(stress_len), .rosc_out(rosc_out),
        .sel_inv(sel_inv), .sel_nand(sel_nand), .sel_nor(sel_nor), .start(start), .ac_dc(ac_dc),
        .en_power_rosc(en_power_rosc), .en_rosc(en_rosc), .meas_stress(meas_stress),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_data(cnt_data), .cnt_ring(cnt_ring),
        .cnt_ovf(cnt_ovf), .busy(busy), .done(done)
    );

    // {sel_inv,sel_nand,sel_nor,start,ac_dc,pwr,en_rosc,meas,valid,ovf,busy,done}
    assign ctl = {sel_inv, sel_nand, sel_nor, start, ac_dc, en_power_rosc, en_rosc,
                  meas_stress, cnt_valid, cnt_ovf, busy, done};

    initial forever begin #5; if (clk_en) clk = ~clk; end
    // Ring output offset 2 ns from the clock grid; period = rosc_div clocks.
    initial begin #2; forever begin #(rosc_div * 5); rosc_out = ~rosc_out; end end

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic test_reset();
        #23;
        n_tests++;
        if (ctl !== 12'h000 || cnt_data !== 8'd0 || cnt_ring !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs ctl=%b data=%0d ring=%0d, want all 0", ctl, cnt_data, cnt_ring);
        end
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();
        n_tests++;
        if (ctl !== 12'h000) begin n_fail++; $display("FAIL reset_idle ctl=%b want 0", ctl); end
    endtask

    task automatic test_single_inv();
        int n;
        rosc_div = 8;
        run = 1; stress_len = 24'd10; ac_mode = 1; ring_mask = 3'b001; cont = 0;
        tick(); run = 0;
        n_tests++;
        if (ctl !== 12'b000_1_1_1_0_0_0_0_1_0) begin n_fail++; $display("FAIL t1_stress_outputs ctl=%b", ctl); end
        n = 0;
        while (start === 1'b1 && n < 100) begin n++; tick(); end
        n_tests++;
        if (n != 10) begin n_fail++; $display("FAIL t1_stress_len got %0d want 10", n); end
        n_tests++;
        if (ctl !== 12'b100_0_0_1_1_1_0_0_1_0) begin n_fail++; $display("FAIL t1_settle_outputs ctl=%b", ctl); end
        n = 0;
        while (cnt_valid !== 1'b1 && n < 2000) begin n++; tick(); end
        n_tests++;
        if (n != 1088) begin n_fail++; $display("FAIL t1_meas_latency got %0d want 1088", n); end
        n_tests++;
        if (cnt_data !== 8'd128 || cnt_ring !== 2'd0 || cnt_ovf !== 1'b0) begin
            n_fail++; $display("FAIL t1_result data=%0d ring=%0d ovf=%b want 128/0/0", cnt_data, cnt_ring, cnt_ovf);
        end
        cnt_ready = 1; tick(); cnt_ready = 0;
        n_tests++;
        if (ctl !== 12'b000_0_0_0_0_0_0_0_0_1) begin n_fail++; $display("FAIL t1_done ctl=%b want done only", ctl); end
        tick();
        n_tests++;
        if (ctl !== 12'h000 || cnt_data !== 8'd128) begin
            n_fail++; $display("FAIL t1_idle_hold ctl=%b data=%0d want 0/128", ctl, cnt_data);
        end
    endtask

    task automatic test_mask_backpressure();
        int n;
        logic nand_seen = 1'b0;
        run = 1; stress_len = 24'd0; ac_mode = 0; ring_mask = 3'b101; cont = 0;
        tick(); run = 0;
        n_tests++;
        if (ctl !== 12'b100_0_0_1_1_1_0_0_1_0) begin n_fail++; $display("FAIL t2_skip_stress ctl=%b", ctl); end
        n = 0;
        while (cnt_valid !== 1'b1 && n < 2000) begin nand_seen |= sel_nand; n++; tick(); end
        n_tests++;
        if (cnt_valid !== 1'b1 || cnt_ring !== 2'd0 || cnt_data !== 8'd128) begin
            n_fail++; $display("FAIL t2_first valid=%b ring=%0d data=%0d want 1/0/128", cnt_valid, cnt_ring, cnt_data);
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cnt_valid !== 1'b1 || cnt_data !== 8'd128 || cnt_ring !== 2'd0 || sel_inv !== 1'b1) n++;
        end
        n_tests++;
        if (n != 0) begin n_fail++; $display("FAIL t2_stall_stable got %0d unstable cycles want 0", n); end
        cnt_ready = 1; tick(); cnt_ready = 0;
        n_tests++;
        if (ctl !== 12'b001_0_0_1_1_1_0_0_1_0) begin n_fail++; $display("FAIL t2_next_ring ctl=%b want NOR settle", ctl); end
        n = 0;
        while (cnt_valid !== 1'b1 && n < 2000) begin nand_seen |= sel_nand; n++; tick(); end
        n_tests++;
        if (cnt_ring !== 2'd2 || cnt_data !== 8'd128) begin
            n_fail++; $display("FAIL t2_second ring=%0d data=%0d want 2/128", cnt_ring, cnt_data);
        end
        cnt_ready = 1; tick(); cnt_ready = 0;
        n_tests++;
        if (done !== 1'b1 || nand_seen !== 1'b0) begin
            n_fail++; $display("FAIL t2_end done=%b nand_seen=%b want 1/0", done, nand_seen);
        end
    endtask

    task automatic test_overflow();
        int n;
        rosc_div = 4;
        run = 1; stress_len = 24'd0; ring_mask = 3'b001; cont = 0;
        tick(); run = 0;
        n = 0;
        while (cnt_valid !== 1'b1 && n < 2000) begin n++; tick(); end
        n_tests++;
`ifdef ROSC_SAT_CNT_EN
        if (cnt_data !== 8'd255 || cnt_ovf !== 1'b1) begin
            n_fail++; $display("FAIL t3_sat data=%0d ovf=%b want 255/1", cnt_data, cnt_ovf);
        end
`else
        if (cnt_data !== 8'd0 || cnt_ovf !== 1'b1) begin
            n_fail++; $display("FAIL t3_wrap data=%0d ovf=%b want 0/1", cnt_data, cnt_ovf);
        end
`endif
        cnt_ready = 1; tick(); cnt_ready = 0;
        tick();
        n_tests++;
        if (ctl !== 12'h000) begin n_fail++; $display("FAIL t3_idle ctl=%b want 0", ctl); end
        rosc_div = 8;
    endtask

    task automatic test_abort();
        int n;
        run = 1; stress_len = 24'd0; ring_mask = 3'b001; cont = 0;
        tick(); run = 0;
        repeat (100) tick();
        abort = 1; tick(); abort = 0;
        n_tests++;
        if (ctl !== 12'h000) begin n_fail++; $display("FAIL t4_abort_gate ctl=%b want 0", ctl); end
        run = 1; abort = 1; tick(); run = 0; abort = 0;
        tick();
        n_tests++;
        if (ctl !== 12'h000) begin n_fail++; $display("FAIL t4_abort_run ctl=%b want 0", ctl); end
        run = 1; tick(); run = 0;
        n = 0;
        while (cnt_valid !== 1'b1 && n < 2000) begin n++; tick(); end
        abort = 1; tick(); abort = 0;
        n_tests++;
        if (ctl !== 12'h000) begin n_fail++; $display("FAIL t4_abort_report ctl=%b want 0", ctl); end
    endtask

    task automatic test_cont_loop();
        int n;
        run = 1; cont = 1; stress_len = 24'd5; ac_mode = 0; ring_mask = 3'b010;
        tick(); run = 0;
        for (int loop = 0; loop < 2; loop++) begin
            n = 0;
            while (start === 1'b1 && n < 100) begin n++; tick(); end
            n_tests++;
            if (n != 5) begin n_fail++; $display("FAIL t5_stress_len loop%0d got %0d want 5", loop, n); end
            n_tests++;
            if (ctl !== 12'b010_0_0_1_1_1_0_0_1_0) begin n_fail++; $display("FAIL t5_settle loop%0d ctl=%b", loop, ctl); end
            run = 1; ring_mask = 3'b001; stress_len = 24'd2; tick(); run = 0; ring_mask = 3'b010;
            n = 0;
            while (cnt_valid !== 1'b1 && n < 2000) begin n++; tick(); end
            n_tests++;
            if (cnt_ring !== 2'd1 || cnt_data !== 8'd128) begin
                n_fail++; $display("FAIL t5_result loop%0d ring=%0d data=%0d want 1/128", loop, cnt_ring, cnt_data);
            end
            cnt_ready = 1; tick(); cnt_ready = 0;
            n_tests++;
            if (ctl !== 12'b000_1_0_1_0_0_0_0_1_0) begin n_fail++; $display("FAIL t5_restress loop%0d ctl=%b", loop, ctl); end
        end
        tick();
        abort = 1; tick(); abort = 0; cont = 0;
        n_tests++;
        if (ctl !== 12'h000) begin n_fail++; $display("FAIL t5_abort ctl=%b want 0", ctl); end
    endtask

    task automatic test_async_reset();
        int n;
        run = 1; stress_len = 24'd100; ring_mask = 3'b001; cont = 0; ac_mode = 1;
        tick(); run = 0;
        repeat (3) tick();
        clk_en = 0;
        #20 rst_n = 0;
        #1;
        n_tests++;
        if (ctl !== 12'h000 || cnt_data !== 8'd0) begin
            n_fail++; $display("FAIL t6_async ctl=%b data=%0d want 0/0", ctl, cnt_data);
        end
        #10 rst_n = 1;
        clk_en = 1;
        tick(); tick();
        run = 1; stress_len = 24'd3; ring_mask = 3'b000; ac_mode = 0;
        tick(); run = 0;
        n = 0;
        while (start === 1'b1 && n < 100) begin n++; tick(); end
        n_tests++;
        if (n != 3 || ctl !== 12'b000_0_0_0_0_0_0_0_0_1) begin
            n_fail++; $display("FAIL t6_restart stress=%0d ctl=%b want 3/done", n, ctl);
        end
    endtask

    initial begin
        test_reset();
        test_single_inv();
        test_mask_backpressure();
        test_overflow();
        test_abort();
        test_cont_loop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
